// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding and counter sizing.
// Imported by serial_adder; holds no logic of its own.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell, purely combinational.
// Zero latency, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder, LSB first through one full_adder; result W edges after accept.
// Accepts only in IDLE; a stalled consumer holds sum/cout/out_valid in DONE indefinitely.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int            CW   = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t        state_q, state_d;
  logic [W-1:0]  a_sr_q, a_sr_d;
  logic [W-1:0]  b_sr_q, b_sr_d;
  logic [W-1:0]  s_sr_q, s_sr_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fa_sum, fa_cout;
  logic [W-1:0]  s_shift;

  full_adder u_fa (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .sum (fa_sum),
    .cout(fa_cout)
  );

  // New sum bit enters at the MSB; after W shifts the register holds the whole sum.
  assign s_shift = (s_sr_q >> 1) | (W'(fa_sum) << (W - 1));

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_sr_d  = s_shift;
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        // Outputs are captured only here so they stay frozen while the next add runs.
        if (cnt_q == LAST) begin
          sum_d   = s_shift;
          cout_d  = fa_cout;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized scoreboard bench for serial_adder at W=8, W=2 and W=1 instances.
// Expected {cout,sum} is the plain integer a+b+cin, queued at accept and popped on each result handshake.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       iv0, iv1, iv2, or0, or1, or2, c0, c1, c2;
  logic [7:0] a0, b0;
  logic [1:0] a1, b1;
  logic       a2, b2;
  logic       ir0, ir1, ir2, ov0, ov1, ov2, co0, co1, co2;
  logic [7:0] s0;
  logic [1:0] s1;
  logic       s2;

  serial_adder #(.W(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0), .cin(c0),
    .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0));
  serial_adder #(.W(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(c1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1));
  serial_adder #(.W(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .cin(c2),
    .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2));

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int q0[$];
  int q1[$];
  int q2[$];

  function automatic logic rdy(int k);
    case (k)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

  function automatic logic vld(int k);
    case (k)
      0:       return ov0;
      1:       return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic int res(int k);
    case (k)
      0:       return int'({co0, s0});
      1:       return int'({co1, s1});
      default: return int'({co2, s2});
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    tot_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic drive(int k, logic v, int a, int b, int c);
    case (k)
      0: begin iv0 = v; a0 = 8'(a); b0 = 8'(b); c0 = c[0]; end
      1: begin iv1 = v; a1 = 2'(a); b1 = 2'(b); c1 = c[0]; end
      default: begin iv2 = v; a2 = a[0]; b2 = b[0]; c2 = c[0]; end
    endcase
  endtask

  task automatic push(int k, int v);
    case (k)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop_cmp(int k);
    int n;
    int exp;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    if (n == 0) begin
      tot_cnt++;
      $display("FAIL unexpected_result dut%0d: got %0d, expected no result", k, res(k));
    end else begin
      case (k)
        0:       exp = q0.pop_front();
        1:       exp = q1.pop_front();
        default: exp = q2.pop_front();
      endcase
      check($sformatf("result_dut%0d", k), res(k), exp);
    end
  endtask

  // Monitor: compares every completed result handshake against the queued model value.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ov0 && or0) pop_cmp(0);
      if (ov1 && or1) pop_cmp(1);
      if (ov2 && or2) pop_cmp(2);
    end
  end

  // One operation: offer operands, push a+b+cin, measure latency and in_ready-low span.
  task automatic op(int k, int a, int b, int c, int w, bit chk_ir);
    int lat;
    int low;
    @(negedge clk);
    drive(k, 1'b1, a, b, c);
    lat = 0;
    while (!rdy(k) && lat < 100) begin @(negedge clk); lat++; end
    check("accept_ready", int'(rdy(k)), 1);
    @(posedge clk); #1;
    drive(k, 1'b0, 0, 0, 0);
    push(k, a + b + c);
    lat = 0;
    low = 0;
    while (!vld(k) && lat < 100) begin
      if (!rdy(k)) low++;
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency_w%0d", w), lat, w);
    if (chk_ir) begin
      while (!rdy(k) && low < 100) begin low++; @(posedge clk); #1; end
      check($sformatf("in_ready_low_w%0d", w), low, w + 1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    drive(0, 1'b0, 0, 0, 0);
    drive(1, 1'b0, 0, 0, 0);
    drive(2, 1'b0, 0, 0, 0);
    or0 = 1'b1; or1 = 1'b1; or2 = 1'b1;
    #12;
    check("rst_out_valid", int'(ov0), 0);
    check("rst_in_ready", int'(ir0), 1);
    check("rst_result", res(0), 0);
    check("rst_in_ready_w2", int'(ir1), 1);
    check("rst_in_ready_w1", int'(ir2), 1);
    @(negedge clk);
    rst_n = 1'b1;

    op(0, 8'h00, 8'h00, 0, 8, 1);
    op(0, 8'hFF, 8'h01, 0, 8, 1);
    op(0, 8'hA5, 8'h5A, 1, 8, 1);
    for (int i = 0; i < 20; i++) begin
      op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
         int'($urandom_range(0, 1)), 8, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Backpressure: result held while new operands are offered and refused.
    or0 = 1'b0;
    op(0, 8'h12, 8'h34, 0, 8, 0);
    @(negedge clk);
    drive(0, 1'b1, 8'hFF, 8'h01, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", int'(ov0), 1);
      check("bp_result", res(0), 'h046);
      check("bp_in_ready", int'(ir0), 0);
    end
    @(posedge clk); #1;
    or0 = 1'b1;
    drive(0, 1'b0, 0, 0, 0);
    seen = 0;
    repeat (12) begin @(negedge clk); if (ov0) seen++; end
    check("bp_no_extra_result", seen, 1);

    // Reset in the third RUN cycle discards the operation.
    @(negedge clk);
    drive(0, 1'b1, 8'hF0, 8'h0F, 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", int'(ov0), 0);
    check("midrst_in_ready", int'(ir0), 1);
    check("midrst_result", res(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 8'h12, 8'h34, 0, 8, 1);

    for (int i = 0; i < 32; i++) op(1, (i >> 3) & 3, (i >> 1) & 3, i & 1, 2, 1);

    op(2, 1, 1, 1, 1, 1);
    for (int i = 0; i < 6; i++)
      op(2, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1, 1);

    repeat (4) @(negedge clk);
    check("drained_q_w8", q0.size(), 0);
    check("drained_q_w2", q1.size(), 0);
    check("drained_q_w1", q2.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
